// File: rtl/pwm_capture.sv
// PWM/square-wave capture: measures period (rise to rise) and high time in clk cycles,
// publishing one result per period with a one-cycle valid strobe and a sticky timeout flag.
module pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = (2**CNT_W) - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             timeout_flag
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating increment keeps the counter pinned at TIMEOUT when an edge wins that cycle.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == TIMEOUT_C) ? TIMEOUT_C : (v + CNT_ONE);
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_dly_q;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       high_reg_q, high_reg_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_q, high_d;
    logic                   valid_q, valid_d;
    logic                   tflag_q, tflag_d;
    logic                   s_s, rise_s, fall_s;

    assign s_s    = sync_q[SYNC_STAGES-1];
    assign rise_s = s_s & ~s_dly_q;
    assign fall_s = ~s_s & s_dly_q;

    // Input synchronizer chain plus one extra stage for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= {SYNC_STAGES{1'b0}};
            s_dly_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_dly_q <= s_s;
        end
    end

    // State, counter and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            high_reg_q <= CNT_ZERO;
            period_q   <= CNT_ZERO;
            high_q     <= CNT_ZERO;
            valid_q    <= 1'b0;
            tflag_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            high_reg_q <= high_reg_d;
            period_q   <= period_d;
            high_q     <= high_d;
            valid_q    <= valid_d;
            tflag_q    <= tflag_d;
        end
    end

    // Next-state logic: disable beats edges, edges beat timeout.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        high_reg_d = high_reg_q;
        period_d   = period_q;
        high_d     = high_q;
        valid_d    = 1'b0;
        tflag_d    = tflag_q;
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
            tflag_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                    cnt_d   = CNT_ZERO;
                end
                ST_ARM: begin
                    if (rise_s) begin
                        state_d = ST_HIGH;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d   = CNT_ZERO;
                    end
                end
                ST_HIGH: begin
                    if (fall_s) begin
                        high_reg_d = cnt_q;
                        cnt_d      = sat_inc(cnt_q);
                        state_d    = ST_LOW;
                    end else if (cnt_q == TIMEOUT_C) begin
                        tflag_d    = 1'b1;
                        cnt_d      = CNT_ZERO;
                        state_d    = ST_ARM;
                    end else begin
                        cnt_d      = sat_inc(cnt_q);
                    end
                end
                ST_LOW: begin
                    if (rise_s) begin
                        period_d = cnt_q;
                        high_d   = high_reg_q;
                        valid_d  = 1'b1;
                        tflag_d  = 1'b0;
                        cnt_d    = CNT_ONE;
                        state_d  = ST_HIGH;
                    end else if (cnt_q == TIMEOUT_C) begin
                        tflag_d  = 1'b1;
                        cnt_d    = CNT_ZERO;
                        state_d  = ST_ARM;
                    end else begin
                        cnt_d    = sat_inc(cnt_q);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    assign period_out   = period_q;
    assign high_out     = high_q;
    assign meas_valid   = valid_q;
    assign timeout_flag = tflag_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: the driver pushes the expected result at each rise,
// a negedge monitor pops and compares whenever meas_valid is seen.
module tb_pwm_capture;

    localparam int CNT_W = 16;
    localparam int TO    = 1000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             pwm_in = 1'b0;
    logic             enable = 1'b0;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             meas_valid;
    logic             timeout_flag;

    logic [31:0]      sb_q[$];
    int               checks = 0;
    int               failures = 0;
    logic             armed = 1'b0;
    int               prev_h = 0;
    int               prev_p = 0;
    logic [15:0]      last_p = 16'd0;
    logic [15:0]      last_h = 16'd0;

    pwm_capture #(
        .CNT_W(CNT_W),
        .SYNC_STAGES(2),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pwm_in(pwm_in),
        .enable(enable),
        .period_out(period_out),
        .high_out(high_out),
        .meas_valid(meas_valid),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Rising edge of pwm_in: if a period was being measured, its result is now due.
    task automatic rise_edge();
        pwm_in = 1'b1;
        if (armed) begin
            sb_q.push_back({prev_p[15:0], prev_h[15:0]});
            last_p = prev_p[15:0];
            last_h = prev_h[15:0];
        end
        armed = 1'b1;
    endtask

    task automatic drive(input int h, input int l);
        rise_edge();
        cyc(h);
        pwm_in = 1'b0;
        cyc(l);
        prev_h = h;
        prev_p = h + l;
    endtask

    // Monitor: every meas_valid must match the oldest expected result.
    always @(negedge clk) begin
        logic [31:0] exp_v;
        if (rst && meas_valid) begin
            if (sb_q.size() == 0) begin
                checks = checks + 1;
                failures = failures + 1;
                $display("FAIL unexpected_valid: got period=%0d high=%0d expected no valid at %0t",
                         period_out, high_out, $time);
            end else begin
                exp_v = sb_q.pop_front();
                check("period", {16'd0, period_out}, {16'd0, exp_v[31:16]});
                check("high", {16'd0, high_out}, {16'd0, exp_v[15:0]});
                check("flag_at_valid", {31'd0, timeout_flag}, 32'd0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_period", {16'd0, period_out}, 32'd0);
        check("rst_high", {16'd0, high_out}, 32'd0);
        check("rst_valid", {31'd0, meas_valid}, 32'd0);
        check("rst_flag", {31'd0, timeout_flag}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b1;
        cyc(5);

        // 333/333: first result after the second rise, then every period.
        repeat (4) drive(333, 333);

        // 100/300 then 300/100: transition result is the last full old period.
        repeat (3) drive(100, 300);
        repeat (3) drive(300, 100);

        // Timeout with pwm_in stuck high.
        repeat (3) drive(50, 50);
        rise_edge();
        armed = 1'b0;
        cyc(TO + 2);
        check("tmo_flag_early", {31'd0, timeout_flag}, 32'd0);
        cyc(1);
        check("tmo_flag_set", {31'd0, timeout_flag}, 32'd1);
        check("tmo_period_hold", {16'd0, period_out}, {16'd0, last_p});
        check("tmo_high_hold", {16'd0, high_out}, {16'd0, last_h});
        cyc(20);
        pwm_in = 1'b0;
        cyc(60);
        check("tmo_flag_sticky", {31'd0, timeout_flag}, 32'd1);
        repeat (3) drive(50, 50);

        // enable dropped mid-LOW.
        rise_edge();
        cyc(100);
        pwm_in = 1'b0;
        cyc(150);
        enable = 1'b0;
        armed = 1'b0;
        cyc(10);
        check("dis_flag", {31'd0, timeout_flag}, 32'd0);
        check("dis_valid", {31'd0, meas_valid}, 32'd0);
        check("dis_period_hold", {16'd0, period_out}, {16'd0, last_p});
        check("dis_high_hold", {16'd0, high_out}, {16'd0, last_h});
        cyc(100);
        enable = 1'b1;
        cyc(50);
        repeat (3) drive(100, 300);

        // Asynchronous reset mid-HIGH.
        rise_edge();
        cyc(50);
        #2;
        rst = 1'b0;
        #1;
        check("arst_period", {16'd0, period_out}, 32'd0);
        check("arst_high", {16'd0, high_out}, 32'd0);
        check("arst_valid", {31'd0, meas_valid}, 32'd0);
        check("arst_flag", {31'd0, timeout_flag}, 32'd0);
        armed = 1'b0;
        @(negedge clk);
        pwm_in = 1'b0;
        cyc(5);
        rst = 1'b1;
        cyc(10);
        repeat (3) drive(20, 20);

        // Fastest waveform: 1 high / 1 low.
        repeat (20) drive(1, 1);

        cyc(20);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
